logic_cell_bank: RTL and testbench
==================================

LOGIC_CELL_BANK -- requirements
Module: logic_cell_bank

Interface
REQ-001 Parameter N_CELLS, default 4, range 2..32; number of independent logic cells in the bank.
REQ-002 Parameter CNT_W, default $clog2(N_CELLS)+1; width of the shift cycle counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start, stop, shift_req  input  1 each  control commands, sampled each cycle.
REQ-006 ta1, ta2, tb1, tb2, ba1, ba2, bb1, bb2  input  N_CELLS each  per-cell mux data inputs.
REQ-007 tsl, tab, bsl, bab, tbs  input  N_CELLS each  per-cell mux selects.
REQ-008 qdi, qds, qen, qst, qrt  input  N_CELLS each  per-cell register direct data, data select, enable, sync set, sync clear.
REQ-009 scan_in  input  1  serial data into cell 0 during shift.
REQ-010 tz, bz, cz  output  N_CELLS each  per-cell combinational mux outputs.
REQ-011 qz  output  N_CELLS  per-cell register outputs.
REQ-012 scan_out  output  1  equals qz[N_CELLS-1].
REQ-013 busy  output  1  high in SHIFT; shift_done  output  1  one-cycle pulse.
REQ-014 state  output  2  current FSM state encoding.

Function
REQ-015 Per cell i: tz = tab ? (tsl ? tb2 : tb1) : (tsl ? ta2 : ta1).
REQ-016 Per cell i: bz = bab ? (bsl ? bb2 : bb1) : (bsl ? ba2 : ba1).
REQ-017 Per cell i: cz = tbs ? bz : tz; tz/bz/cz are combinational in every state, with zero latency.
REQ-018 Per cell i: register data d = qds ? qdi : cz.
REQ-019 FSM states: IDLE=0, RUN=1, SHIFT=2; encoding 3 is unused and recovers to IDLE on the next edge.
REQ-020 IDLE: qz holds; start -> RUN.
REQ-021 RUN: per cell, qrt -> qz=0, else qst -> qz=1, else qen -> qz=d, else hold; qrt has priority over qst.
REQ-022 RUN: stop -> IDLE; else shift_req -> SHIFT with the counter loaded to 0; the cell update of that same cycle still applies.
REQ-023 SHIFT: each cycle qz[0]<=scan_in and qz[i]<=qz[i-1]; qen, qst, qrt and qds are ignored.
REQ-024 SHIFT: the counter increments each cycle; on the cycle the counter equals N_CELLS-1, the shift is performed, shift_done pulses, and the next state is RUN.
REQ-025 Exactly N_CELLS shift edges occur per SHIFT episode, so the full bank content exits via scan_out.
REQ-026 stop in SHIFT -> IDLE immediately, without the shift on that edge and without shift_done; stop has priority over every other command in every state.
REQ-027 start in RUN or SHIFT and shift_req outside RUN are ignored.
REQ-028 busy = (state==SHIFT); shift_done is registered and is high for exactly one cycle after the final shift edge.

Reset
REQ-029 rst_n low: asynchronously qz=0, state=IDLE, counter=0, shift_done=0, busy=0.
REQ-030 Reset asserted mid-SHIFT aborts the shift with no shift_done; after release the block idles until start.
REQ-031 Release of rst_n is synchronised by the integrator; the block takes no action on the release edge.

Structure
REQ-032 Shared package logic_cell_pkg holds the state enum (IDLE/RUN/SHIFT) and the default N_CELLS constant.
REQ-033 Sub-module lcell_mux implements the one-cell tz/bz/cz tree (REQ-015..017) and is instantiated N_CELLS times in a generate loop.
REQ-034 The registers, counter and FSM reside in logic_cell_bank; there are no latches and no multi-clock paths.

Verification
REQ-035 Mux sweep, N=4: drive all 2^13 combinations for cell 0 -> tz/bz/cz match REQ-015..017 in the same cycle; other cells are unaffected.
REQ-036 RUN load: start, then qen=4'b1010, qds=0, cz=4'b1111 -> qz=4'b1010 after one edge; cells with qen=0 hold.
REQ-037 Set/clear priority: in RUN, qrt=qst=4'b0001, qen=4'b1111 -> qz[0]=0; qst only -> qz[0]=1, regardless of d.
REQ-038 Shift: qz=4'b1011, shift_req, scan_in=0 -> scan_out sequence 1,0,1,1 over 4 edges; shift_done pulses once; state returns to RUN; qz=0.
REQ-039 Abort: stop on the 2nd SHIFT cycle -> IDLE next edge, no shift_done, qz frozen at its 1-shift value; a separate run with rst_n low mid-shift -> qz=0, IDLE.
REQ-040 Command conflicts: start+stop in IDLE -> stays IDLE; shift_req+stop in RUN -> IDLE; shift_req in IDLE -> ignored.

Source files
------------

// File: rtl/logic_cell_pkg.sv
// Shared definitions for the logic cell bank.
//   N_CELLS_DEF : default number of cells in a bank
//   lcb_state_e : bank control FSM states (encoding 2'd3 is unused)
package logic_cell_pkg;

    localparam int N_CELLS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SHIFT = 2'd2
    } lcb_state_e;

endpackage

// File: rtl/lcell_mux.sv
// One cell's combinational mux tree.
//   ta1/ta2/tb1/tb2, tsl/tab : top mux data and selects  -> tz
//   ba1/ba2/bb1/bb2, bsl/bab : bottom mux data and selects -> bz
//   tbs                      : picks bz (1) or tz (0)       -> cz
module lcell_mux (
    input  logic ta1,
    input  logic ta2,
    input  logic tb1,
    input  logic tb2,
    input  logic ba1,
    input  logic ba2,
    input  logic bb1,
    input  logic bb2,
    input  logic tsl,
    input  logic tab,
    input  logic bsl,
    input  logic bab,
    input  logic tbs,
    output logic tz,
    output logic bz,
    output logic cz
);

    logic t_a, t_b, b_a, b_b;

    // The sl select picks within a pair; the ab select then picks the pair.
    assign t_a = tsl ? ta2 : ta1;
    assign t_b = tsl ? tb2 : tb1;
    assign b_a = bsl ? ba2 : ba1;
    assign b_b = bsl ? bb2 : bb1;

    assign tz = tab ? t_b : t_a;
    assign bz = bab ? b_b : b_a;
    assign cz = tbs ? bz : tz;

endmodule

// File: rtl/logic_cell_bank.sv
// Bank of N_CELLS logic cells: per-cell combinational mux tree plus one
// register per cell, controlled by an IDLE/RUN/SHIFT FSM. In RUN the
// registers load/set/clear per cell; in SHIFT they form a scan chain from
// scan_in (cell 0) to scan_out (cell N_CELLS-1) for exactly N_CELLS edges.
//   clk, rst_n                 : clock, async active-low reset
//   start, stop, shift_req     : commands; stop always wins
//   ta*/tb*/ba*/bb*, selects   : per-cell mux inputs -> tz, bz, cz
//   qdi, qds, qen, qst, qrt    : per-cell register controls (RUN only)
//   scan_in, scan_out          : scan chain ends
//   qz                         : register outputs
//   busy, shift_done, state    : status; shift_done pulses after the last shift
//
// Command semantics: commands are level-sampled on every rising edge; there
// is no handshake, so a command held high acts on every edge it is present.
module logic_cell_bank
    import logic_cell_pkg::*;
#(
    parameter int N_CELLS = N_CELLS_DEF,
    parameter int CNT_W   = $clog2(N_CELLS) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               shift_req,
    input  logic [N_CELLS-1:0] ta1,
    input  logic [N_CELLS-1:0] ta2,
    input  logic [N_CELLS-1:0] tb1,
    input  logic [N_CELLS-1:0] tb2,
    input  logic [N_CELLS-1:0] ba1,
    input  logic [N_CELLS-1:0] ba2,
    input  logic [N_CELLS-1:0] bb1,
    input  logic [N_CELLS-1:0] bb2,
    input  logic [N_CELLS-1:0] tsl,
    input  logic [N_CELLS-1:0] tab,
    input  logic [N_CELLS-1:0] bsl,
    input  logic [N_CELLS-1:0] bab,
    input  logic [N_CELLS-1:0] tbs,
    input  logic [N_CELLS-1:0] qdi,
    input  logic [N_CELLS-1:0] qds,
    input  logic [N_CELLS-1:0] qen,
    input  logic [N_CELLS-1:0] qst,
    input  logic [N_CELLS-1:0] qrt,
    input  logic               scan_in,
    output logic [N_CELLS-1:0] tz,
    output logic [N_CELLS-1:0] bz,
    output logic [N_CELLS-1:0] cz,
    output logic [N_CELLS-1:0] qz,
    output logic               scan_out,
    output logic               busy,
    output logic               shift_done,
    output logic [1:0]         state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CELLS - 1);

    lcb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_CELLS-1:0] qz_q, qz_d;
    logic               done_q, done_d;
    logic [N_CELLS-1:0] d_vec;
    logic [N_CELLS-1:0] run_upd;

    for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
        lcell_mux u_mux (
            .ta1 (ta1[i]), .ta2 (ta2[i]), .tb1 (tb1[i]), .tb2 (tb2[i]),
            .ba1 (ba1[i]), .ba2 (ba2[i]), .bb1 (bb1[i]), .bb2 (bb2[i]),
            .tsl (tsl[i]), .tab (tab[i]), .bsl (bsl[i]), .bab (bab[i]),
            .tbs (tbs[i]),
            .tz  (tz[i]),  .bz  (bz[i]),  .cz  (cz[i])
        );
    end

    assign d_vec = (qds & qdi) | (~qds & cz);

    // Per-cell RUN update: clear beats set, set beats enable, else hold.
    assign run_upd = ~qrt & (qst | (qen & d_vec) | (~qen & qz_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qz_d    = qz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!stop && start) state_d = RUN;
            end
            RUN: begin
                qz_d = run_upd;
                if (stop) begin
                    state_d = IDLE;
                end else if (shift_req) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // stop aborts before this edge's shift takes effect.
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    qz_d  = {qz_q[N_CELLS-2:0], scan_in};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qz_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qz_q    <= qz_d;
            done_q  <= done_d;
        end
    end

    assign qz         = qz_q;
    assign scan_out   = qz_q[N_CELLS-1];
    assign busy       = (state_q == SHIFT);
    assign shift_done = done_q;
    assign state      = state_q;

endmodule

// File: tb/tb_logic_cell_bank.sv
module tb_logic_cell_bank;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start, stop, shift_req, scan_in;
    logic [N-1:0] ta1, ta2, tb1, tb2, ba1, ba2, bb1, bb2;
    logic [N-1:0] tsl, tab, bsl, bab, tbs;
    logic [N-1:0] qdi, qds, qen, qst, qrt;
    logic [N-1:0] tz, bz, cz, qz;
    logic         scan_out, busy, shift_done;
    logic [1:0]   state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: mode 0=idle 1=run 2=shift, shifts done so far.
    int           m_mode;
    logic [N-1:0] m_qz;
    int           m_shifts;
    logic         m_done;

    logic [N-1:0] seq_exp;

    logic_cell_bank #(.N_CELLS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .shift_req(shift_req),
        .ta1(ta1), .ta2(ta2), .tb1(tb1), .tb2(tb2),
        .ba1(ba1), .ba2(ba2), .bb1(bb1), .bb2(bb2),
        .tsl(tsl), .tab(tab), .bsl(bsl), .bab(bab), .tbs(tbs),
        .qdi(qdi), .qds(qds), .qen(qen), .qst(qst), .qrt(qrt),
        .scan_in(scan_in),
        .tz(tz), .bz(bz), .cz(cz), .qz(qz),
        .scan_out(scan_out), .busy(busy), .shift_done(shift_done), .state(state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_mux(output logic [N-1:0] etz, output logic [N-1:0] ebz,
                                    output logic [N-1:0] ecz);
        for (int i = 0; i < N; i++) begin
            if (tab[i]) etz[i] = tsl[i] ? tb2[i] : tb1[i];
            else        etz[i] = tsl[i] ? ta2[i] : ta1[i];
            if (bab[i]) ebz[i] = bsl[i] ? bb2[i] : bb1[i];
            else        ebz[i] = bsl[i] ? ba2[i] : ba1[i];
            ecz[i] = tbs[i] ? ebz[i] : etz[i];
        end
    endfunction

    task automatic model_reset();
        m_mode   = 0;
        m_qz     = '0;
        m_shifts = 0;
        m_done   = 1'b0;
    endtask

    task automatic check_comb();
        logic [N-1:0] etz, ebz, ecz;
        ref_mux(etz, ebz, ecz);
        check("tz", 32'(tz), 32'(etz));
        check("bz", 32'(bz), 32'(ebz));
        check("cz", 32'(cz), 32'(ecz));
    endtask

    task automatic check_seq();
        check("qz", 32'(qz), 32'(m_qz));
        check("state", 32'(state), 32'(m_mode));
        check("busy", 32'(busy), 32'(m_mode == 2));
        check("shift_done", 32'(shift_done), 32'(m_done));
        check("scan_out", 32'(scan_out), 32'(m_qz[N-1]));
    endtask

    // One clock: check comb outputs mid-cycle, predict, clock, check registers.
    task automatic step();
        logic [N-1:0] etz, ebz, ecz, nq;
        int           nmode, nsh;
        logic         nd;
        @(negedge clk);
        #1;
        check_comb();
        ref_mux(etz, ebz, ecz);
        nmode = m_mode;
        nq    = m_qz;
        nsh   = m_shifts;
        nd    = 1'b0;
        if (m_mode == 0) begin
            if (!stop && start) nmode = 1;
        end else if (m_mode == 1) begin
            for (int i = 0; i < N; i++) begin
                if (qrt[i])      nq[i] = 1'b0;
                else if (qst[i]) nq[i] = 1'b1;
                else if (qen[i]) nq[i] = qds[i] ? qdi[i] : ecz[i];
            end
            if (stop) nmode = 0;
            else if (shift_req) begin
                nmode = 2;
                nsh   = 0;
            end
        end else begin
            if (stop) nmode = 0;
            else begin
                for (int i = N - 1; i > 0; i--) nq[i] = m_qz[i-1];
                nq[0] = scan_in;
                nsh++;
                if (nsh == N) begin
                    nmode = 1;
                    nd    = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_mode   = nmode;
        m_qz     = nq;
        m_shifts = nsh;
        m_done   = nd;
        check_seq();
    endtask

    // ---------------- driver helpers ----------------
    task automatic clear_inputs();
        {start, stop, shift_req, scan_in} = 4'b0;
        {ta1, ta2, tb1, tb2, ba1, ba2, bb1, bb2} = '0;
        {tsl, tab, bsl, bab, tbs} = '0;
        {qdi, qds, qen, qst, qrt} = '0;
    endtask

    task automatic rand_data();
        ta1 = N'($urandom); ta2 = N'($urandom); tb1 = N'($urandom); tb2 = N'($urandom);
        ba1 = N'($urandom); ba2 = N'($urandom); bb1 = N'($urandom); bb2 = N'($urandom);
        tsl = N'($urandom); tab = N'($urandom); bsl = N'($urandom);
        bab = N'($urandom); tbs = N'($urandom);
        qdi = N'($urandom); qds = N'($urandom); qen = N'($urandom);
        qst = N'($urandom) & N'($urandom);
        qrt = N'($urandom) & N'($urandom) & N'($urandom);
        scan_in = 1'($urandom);
    endtask

    task automatic load_qz(input logic [N-1:0] val);
        qds = '1; qdi = val; qen = '1; qst = '0; qrt = '0;
        step();
        qen = '0; qds = '0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_seq();
        check("reset_qz", 32'(qz), 32'h0);
        check("reset_state", 32'(state), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mux sweep on cell 0, other cells held at fixed random data.
        rand_data();
        {qdi, qds, qen, qst, qrt} = '0;
        scan_in = 1'b0;
        for (int v = 0; v < 8192; v++) begin
            logic [12:0] v13;
            v13 = 13'(v);
            {ta1[0], ta2[0], tb1[0], tb2[0], ba1[0], ba2[0], bb1[0], bb2[0],
             tsl[0], tab[0], bsl[0], bab[0], tbs[0]} = v13;
            #1;
            check_comb();
        end
        check("sweep_idle_state", 32'(state), 32'h0);
        check("sweep_idle_qz", 32'(qz), 32'h0);

        // Command conflicts in IDLE.
        clear_inputs();
        start = 1'b1; stop = 1'b1;
        step();
        check("start_stop_idle", 32'(state), 32'h0);
        start = 1'b0; stop = 1'b0; shift_req = 1'b1;
        step();
        check("shift_req_idle", 32'(state), 32'h0);
        shift_req = 1'b0; start = 1'b1;
        step();
        check("start_to_run", 32'(state), 32'h1);
        start = 1'b0;

        // RUN load with cz all ones, enable on cells 1 and 3.
        ta1 = '1; qen = 4'b1010; qds = '0;
        step();
        check("run_load", 32'(qz), 32'hA);

        // Clear beats set; set beats d.
        qrt = 4'b0001; qst = 4'b0001; qen = '1;
        step();
        check("clr_prio", 32'(qz[0]), 32'h0);
        qrt = '0; qst = 4'b0001; ta1 = '0; qen = '1;
        step();
        check("set_prio", 32'(qz[0]), 32'h1);
        qst = '0; qen = '0;

        // Full shift-out of 1011.
        load_qz(4'b1011);
        shift_req = 1'b1;
        step();
        check("enter_shift", 32'(state), 32'h2);
        check("busy_shift", 32'(busy), 32'h1);
        shift_req = 1'b0; scan_in = 1'b0;
        qen = '1; qst = '1; qds = '1; qdi = '1;
        seq_exp = 4'b1011;
        for (int k = 0; k < N; k++) begin
            check($sformatf("scan_seq%0d", k), 32'(scan_out), 32'(seq_exp[N-1-k]));
            step();
        end
        check("shift_done_pulse", 32'(shift_done), 32'h1);
        check("shift_back_run", 32'(state), 32'h1);
        check("shift_qz_zero", 32'(qz), 32'h0);
        qen = '0; qst = '0; qds = '0;
        step();
        check("shift_done_once", 32'(shift_done), 32'h0);

        // Abort with stop on the second SHIFT cycle.
        load_qz(4'b1011);
        shift_req = 1'b1;
        step();
        shift_req = 1'b0; scan_in = 1'b0;
        step();
        stop = 1'b1;
        step();
        check("abort_state", 32'(state), 32'h0);
        check("abort_qz", 32'(qz), 32'h6);
        check("abort_no_done", 32'(shift_done), 32'h0);
        stop = 1'b0;
        step();
        check("abort_no_done_late", 32'(shift_done), 32'h0);

        // shift_req with stop in RUN.
        start = 1'b1;
        step();
        start = 1'b0; shift_req = 1'b1; stop = 1'b1;
        step();
        check("shreq_stop_run", 32'(state), 32'h0);
        shift_req = 1'b0; stop = 1'b0;

        // Reset in the middle of a shift.
        start = 1'b1;
        step();
        start = 1'b0;
        load_qz(4'b1101);
        shift_req = 1'b1;
        step();
        shift_req = 1'b0; scan_in = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid_qz", 32'(qz), 32'h0);
        check("rst_mid_state", 32'(state), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_done", 32'(shift_done), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_idle", 32'(state), 32'h0);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            rand_data();
            start     = ($urandom_range(0, 3) == 0);
            stop      = ($urandom_range(0, 15) == 0);
            shift_req = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
